vram_dma: RTL

- Bulk copy engine that streams bytes from CPU-side work RAM into GPU VRAM (pattern memory, object memory, nametables) through the VRAM write interface: `data`, `address`, `write_enable`.
- Sits between the CPU bus glue and the GPU. Writes are issued only while the video timing block asserts `writable`, and the transfer pauses transparently otherwise.
- Lets game code refresh all object memory (256 B) inside one blanking window without per-byte CPU stores.

---
 rtl/gpu_pkg.sv | 26 ++
 rtl/vram_dma_skid.sv | 66 ++++++
 rtl/vram_dma.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared GPU-side definitions used by the VRAM DMA engine:
//   - VRAM_ADDR_WIDTH : width of a VRAM byte address (4 KiB VRAM)
//   - *_BASE          : start addresses of the VRAM regions
//   - dma_state_t     : DMA controller states
// -----------------------------------------------------------------------------
package gpu_pkg;

    localparam int VRAM_ADDR_WIDTH = 12;

    // VRAM memory map: pattern memory (background / foreground), nametables,
    // object memory.
    localparam logic [VRAM_ADDR_WIDTH-1:0] PMB_BASE  = 12'h000;
    localparam logic [VRAM_ADDR_WIDTH-1:0] PMF_BASE  = 12'h200;
    localparam logic [VRAM_ADDR_WIDTH-1:0] NTBL_BASE = 12'h400;
    localparam logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE  = 12'h800;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } dma_state_t;

endpackage

// File: rtl/vram_dma_skid.sv
// -----------------------------------------------------------------------------
// vram_dma_skid
// One-entry hold register for a fetched byte and its VRAM address. Used when
// the VRAM write window closes after a byte has been read from work RAM but
// before it could be written, so the byte is retried instead of re-fetched.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   load       : capture load_data / load_addr and set valid
//   clear      : drop the held entry (clear wins over load)
//   load_data  : byte to hold
//   load_addr  : VRAM address of that byte
//   valid      : an entry is held
//   data, addr : held byte and address
// -----------------------------------------------------------------------------
module vram_dma_skid #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            addr_d  = load_addr;
        end
    end

    // NOTE: this is a single flop entry, not a RAM array, so resetting it is
    // cheap and keeps its outputs defined from reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign addr  = addr_q;

endmodule

// File: rtl/vram_dma.sv
// -----------------------------------------------------------------------------
// vram_dma
// Bulk copy engine: streams bytes from CPU work RAM into GPU VRAM, writing only
// while the video timing block opens the VRAM write window (writable=1).
// One byte per two cycles (FETCH, WRITE) while the window stays open.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start               : one-cycle pulse, latches src_base/dst_base/length
//   src_base, dst_base  : first source / destination byte address
//   length              : byte count, 0..256
//   abort               : cancel the running transfer
//   writable            : VRAM write window
//   src_addr, src_re    : work-RAM read port (data returns one cycle later)
//   src_data            : work-RAM read data
//   vram_data, vram_address, vram_write_enable : GPU VRAM write port
//   busy                : transfer in progress
//   done                : one-cycle pulse on completion or abort
// -----------------------------------------------------------------------------
module vram_dma
    import gpu_pkg::*;
#(
    parameter int SRC_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 9,
    parameter int VRAM_ADDR_WIDTH = gpu_pkg::VRAM_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [SRC_ADDR_WIDTH-1:0]  src_base,
    input  logic [VRAM_ADDR_WIDTH-1:0] dst_base,
    input  logic [LEN_WIDTH-1:0]       length,
    input  logic                       abort,
    input  logic                       writable,
    output logic [SRC_ADDR_WIDTH-1:0]  src_addr,
    output logic                       src_re,
    input  logic [7:0]                 src_data,
    output logic [7:0]                 vram_data,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic                       vram_write_enable,
    output logic                       busy,
    output logic                       done
);

    dma_state_t                 state_q,        state_d;
    logic [SRC_ADDR_WIDTH-1:0]  src_ptr_q,      src_ptr_d;
    logic [VRAM_ADDR_WIDTH-1:0] dst_ptr_q,      dst_ptr_d;
    logic [LEN_WIDTH-1:0]       remaining_q,    remaining_d;
    logic [7:0]                 vram_data_q,    vram_data_d;
    logic [VRAM_ADDR_WIDTH-1:0] vram_address_q, vram_address_d;
    logic                       vram_we_q,      vram_we_d;
    logic                       busy_q,         busy_d;
    logic                       done_q,         done_d;

    logic                       fetch_now;
    logic                       skid_load, skid_clear, skid_valid;
    logic [7:0]                 skid_data;
    logic [VRAM_ADDR_WIDTH-1:0] skid_addr;

    vram_dma_skid #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (VRAM_ADDR_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (src_data),
        .load_addr (dst_ptr_q),
        .valid     (skid_valid),
        .data      (skid_data),
        .addr      (skid_addr)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case
        // leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        src_ptr_d      = src_ptr_q;
        dst_ptr_d      = dst_ptr_q;
        remaining_d    = remaining_q;
        vram_data_d    = vram_data_q;
        vram_address_d = vram_address_q;
        vram_we_d      = 1'b0;
        fetch_now      = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // abort is ignored here, so start always wins.
                if (start) begin
                    src_ptr_d   = src_base;
                    dst_ptr_d   = dst_base;
                    remaining_d = length;
                    state_d     = (length == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                // abort also suppresses the read, so nothing is left in flight.
                if (abort) begin
                    state_d = FINISH;
                end else if (writable) begin
                    fetch_now = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    skid_clear = 1'b1;
                    state_d    = FINISH;
                end else if (writable) begin
                    // A held byte takes precedence: src_data is stale by then.
                    vram_data_d    = skid_valid ? skid_data : src_data;
                    vram_address_d = skid_valid ? skid_addr : dst_ptr_q;
                    vram_we_d      = 1'b1;
                    skid_clear     = 1'b1;
                    src_ptr_d      = src_ptr_q + 1'b1;
                    dst_ptr_d      = dst_ptr_q + 1'b1;
                    remaining_d    = remaining_q - 1'b1;
                    state_d        = (remaining_q == LEN_WIDTH'(1)) ? FINISH : FETCH;
                end else if (!skid_valid) begin
                    // Window closed with the read data on src_data: park it.
                    skid_load = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == FINISH);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            src_ptr_q      <= '0;
            dst_ptr_q      <= '0;
            remaining_q    <= '0;
            vram_data_q    <= '0;
            vram_address_q <= '0;
            vram_we_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            src_ptr_q      <= src_ptr_d;
            dst_ptr_q      <= dst_ptr_d;
            remaining_q    <= remaining_d;
            vram_data_q    <= vram_data_d;
            vram_address_q <= vram_address_d;
            vram_we_q      <= vram_we_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign src_addr          = src_ptr_q;
    assign src_re            = fetch_now;
    assign vram_data         = vram_data_q;
    assign vram_address      = vram_address_q;
    assign vram_write_enable = vram_we_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule
